// File: rtl/ahb_mem_test_master.sv
// ahb_mem_test_master: AHB-Lite initiator that fills or checks a
// word-aligned TCM region with the pattern seed + i.
//
// Ports:
//   sys_root_clk, sys_root_rstn : clock, async active-low reset
//   start, mode, base_addr,
//   word_cnt, seed              : job request (mode 0 FILL, 1 CHECK)
//   htrans..hwdata              : AHB-Lite manager address/data outputs
//   hready, hresp, hrdata       : AHB-Lite responses from the matrix
//   busy, done, bus_err         : job status
//   fail_cnt, first_fail_addr   : CHECK mismatch results
module ahb_mem_test_master #(
    parameter int unsigned CNT_W = 16,
    parameter logic [3:0]  PROT  = 4'b0011
) (
    input  logic             sys_root_clk,
    input  logic             sys_root_rstn,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_cnt,
    input  logic [31:0]      seed,
    output logic [1:0]       htrans,
    output logic [31:0]      haddr,
    output logic             hwrite,
    output logic [2:0]       hsize,
    output logic [2:0]       hburst,
    output logic [3:0]       hprot,
    output logic [31:0]      hwdata,
    input  logic             hready,
    input  logic [1:0]       hresp,
    input  logic [31:0]      hrdata,
    output logic             busy,
    output logic             done,
    output logic             bus_err,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [31:0]      first_fail_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LAST,
        S_ABORT,
        S_DONE
    } state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    state_t state_q;
    state_t state_d;

    logic             mode_q;
    logic [31:0]      base_q;
    logic [31:0]      seed_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] a_idx_q;
    logic [CNT_W-1:0] d_idx_q;
    logic             dp_q;
    logic             err_q;
    logic [CNT_W-1:0] fail_q;
    logic [31:0]      ffa_q;

    logic             err_rsp;
    logic             accept;
    logic             in_xfer;
    logic             a_done;
    logic             d_done;
    logic             d_err;
    logic             is_last;
    logic             mism;
    logic [31:0]      a_off;
    logic [31:0]      d_off;
    logic [31:0]      d_exp;

    // Only bit 0 of HRESP carries meaning; the mask keeps bit 1 inert.
    assign err_rsp = |(hresp & 2'b01);

    assign accept  = (state_q == S_IDLE) & start;
    assign in_xfer = (state_q == S_ADDR)
                   | (state_q == S_LAST);
    assign a_done  = (state_q == S_ADDR) & hready;
    assign is_last = (a_idx_q == cnt_q - 1'b1);

    // First cycle of a two-cycle ERROR response.
    assign d_err  = in_xfer & dp_q & err_rsp & ~hready;
    assign d_done = dp_q & hready & ~err_rsp;

    assign a_off = {{(32-CNT_W-2){1'b0}}, a_idx_q, 2'b00};
    assign d_off = {{(32-CNT_W-2){1'b0}}, d_idx_q, 2'b00};
    assign d_exp = seed_q + {{(32-CNT_W){1'b0}}, d_idx_q};
    assign mism  = (hrdata != d_exp);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (word_cnt == '0) state_d = S_DONE;
                    else                state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (d_err)                 state_d = S_ABORT;
                else if (hready & is_last) state_d = S_LAST;
            end
            S_LAST: begin
                if (d_err)       state_d = S_ABORT;
                else if (hready) state_d = S_DONE;
            end
            S_ABORT: begin
                if (hready) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_root_clk or negedge sys_root_rstn) begin
        if (!sys_root_rstn) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    always_ff @(posedge sys_root_clk or negedge sys_root_rstn) begin
        if (!sys_root_rstn) begin
            mode_q  <= 1'b0;
            base_q  <= '0;
            seed_q  <= '0;
            cnt_q   <= '0;
            a_idx_q <= '0;
            d_idx_q <= '0;
            dp_q    <= 1'b0;
            err_q   <= 1'b0;
            fail_q  <= '0;
            ffa_q   <= '0;
        end else begin
            if (accept) begin
                mode_q  <= mode;
                base_q  <= base_addr & ~32'h3;
                seed_q  <= seed;
                cnt_q   <= word_cnt;
                a_idx_q <= '0;
                dp_q    <= 1'b0;
                err_q   <= 1'b0;
                fail_q  <= '0;
                ffa_q   <= '0;
            end else begin
                if (a_done) a_idx_q <= a_idx_q + 1'b1;
                // A data phase exists only behind an accepted address.
                if (hready) begin
                    dp_q <= a_done;
                    if (a_done) d_idx_q <= a_idx_q;
                end
                if (d_err) begin
                    dp_q  <= 1'b0;
                    err_q <= 1'b1;
                end
                if (d_done & mode_q & mism) begin
                    if (fail_q != '1) fail_q <= fail_q + 1'b1;
                    if (fail_q == '0) ffa_q <= base_q + d_off;
                end
            end
        end
    end

    assign htrans = (state_q == S_ADDR) ? HT_NONSEQ : HT_IDLE;
    assign haddr  = base_q + a_off;
    assign hwrite = (state_q == S_ADDR) & ~mode_q;
    assign hsize  = 3'b010;
    assign hburst = 3'b000;
    assign hprot  = PROT;
    assign hwdata = d_exp;

    assign busy            = in_xfer | (state_q == S_ABORT);
    assign done            = (state_q == S_DONE);
    assign bus_err         = err_q;
    assign fail_cnt        = fail_q;
    assign first_fail_addr = ffa_q;

endmodule

// File: tb/tb_ahb_mem_test_master.sv
// tb_ahb_mem_test_master: directed and randomized bench with an
// AHB responder/memory model and a pattern reference model.
module tb_ahb_mem_test_master;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start;
    logic             mode;
    logic [31:0]      base_addr;
    logic [CNT_W-1:0] word_cnt;
    logic [31:0]      seed;
    logic [1:0]       htrans;
    logic [31:0]      haddr;
    logic             hwrite;
    logic [2:0]       hsize;
    logic [2:0]       hburst;
    logic [3:0]       hprot;
    logic [31:0]      hwdata;
    logic             hready = 1'b1;
    logic [1:0]       hresp = 2'b00;
    logic [31:0]      hrdata = '0;
    logic             busy;
    logic             done;
    logic             bus_err;
    logic [CNT_W-1:0] fail_cnt;
    logic [31:0]      first_fail_addr;

    ahb_mem_test_master #(
        .CNT_W(CNT_W),
        .PROT (4'b0011)
    ) dut (
        .sys_root_clk   (clk),
        .sys_root_rstn  (rstn),
        .start          (start),
        .mode           (mode),
        .base_addr      (base_addr),
        .word_cnt       (word_cnt),
        .seed           (seed),
        .htrans         (htrans),
        .haddr          (haddr),
        .hwrite         (hwrite),
        .hsize          (hsize),
        .hburst         (hburst),
        .hprot          (hprot),
        .hwdata         (hwdata),
        .hready         (hready),
        .hresp          (hresp),
        .hrdata         (hrdata),
        .busy           (busy),
        .done           (done),
        .bus_err        (bus_err),
        .fail_cnt       (fail_cnt),
        .first_fail_addr(first_fail_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Responder configuration.
    logic        stall_en = 0;
    logic [31:0] stall_addr = 0;
    int          stall_n = 0;
    logic        rnd_stall = 0;
    logic        bad_en = 0;
    logic [31:0] bad_addr = 0;
    logic        err_en = 0;
    logic [31:0] err_addr = 0;

    // Memory and logs.
    logic [31:0] mem [0:63];
    logic [31:0] alog[$];
    int          acyc[$];
    logic [31:0] wlog[$];
    int          wcyc[$];
    logic [1:0]  ht_at [0:4095];
    int          done_n = 0;
    int          done_cyc = 0;
    int          err_cyc = -1;
    int          stab_viol = 0;
    logic        busy_seen = 0;

    // Responder internals.
    logic        pend = 0;
    logic [31:0] p_addr = 0;
    logic        p_write = 0;
    int          p_stall = 0;
    logic        p_err = 0;
    int          p_errc = 0;
    logic        pv_stall = 0;
    logic        pv_errc = 0;
    logic        pv_ns = 0;
    logic [31:0] pv_a = 0;
    logic        pv_w = 0;
    logic        pv_dw = 0;
    logic [31:0] pv_wd = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            pend     = 0;
            hready   = 1;
            hresp    = 0;
            hrdata   = 0;
            pv_stall = 0;
        end else begin
            if (cyc < 4096) ht_at[cyc] = htrans;
            if (busy) busy_seen = 1;
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (pv_stall && !pv_errc) begin
                if (pv_ns && (htrans !== 2'b10 ||
                    haddr !== pv_a || hwrite !== pv_w))
                    stab_viol++;
                if (pv_dw && hwdata !== pv_wd)
                    stab_viol++;
            end
            hready = 1;
            hresp  = 0;
            hrdata = 0;
            pv_errc = 0;
            if (pend) begin
                if (p_err) begin
                    hresp = 2'b01;
                    hready = (p_errc != 0);
                    if (p_errc == 0) begin
                        err_cyc = cyc;
                        pv_errc = 1;
                    end
                    p_errc++;
                end else if (p_stall > 0) begin
                    hready = 0;
                    p_stall--;
                end else if (bad_en && p_addr == bad_addr) begin
                    hrdata = 32'hDEAD;
                end else begin
                    hrdata = mem[p_addr[7:2]];
                end
            end
            pv_dw = pend && p_write;
            pv_wd = hwdata;
            pv_ns = (htrans == 2'b10);
            pv_a  = haddr;
            pv_w  = hwrite;
            pv_stall = !hready;
            if (hready) begin
                if (pend && !p_err && p_write) begin
                    mem[p_addr[7:2]] = hwdata;
                    wlog.push_back(hwdata);
                    wcyc.push_back(cyc);
                end
                if (htrans == 2'b10) begin
                    alog.push_back(haddr);
                    acyc.push_back(cyc);
                    pend    = 1;
                    p_addr  = haddr;
                    p_write = hwrite;
                    p_err   = err_en && haddr == err_addr;
                    p_errc  = 0;
                    if (stall_en && haddr == stall_addr)
                        p_stall = stall_n;
                    else if (rnd_stall)
                        p_stall = $urandom_range(0, 2);
                    else
                        p_stall = 0;
                end else begin
                    pend = 0;
                end
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        alog.delete();
        acyc.delete();
        wlog.delete();
        wcyc.delete();
        busy_seen = 0;
        err_cyc = -1;
        stab_viol = 0;
    endtask

    int s_cyc;

    task automatic wait_done(input int d0, input string tag);
        for (int k = 0; k < 400 && done_n == d0; k++) step();
        chk(tag, done_n - d0, 1);
    endtask

    task automatic run(input logic m, input logic [31:0] b,
                       input logic [15:0] n, input logic [31:0] sd);
        int d0;
        clear_logs();
        d0 = done_n;
        mode = m;
        base_addr = b;
        word_cnt = n;
        seed = sd;
        start = 1;
        s_cyc = cyc;
        step();
        start = 0;
        wait_done(d0, "done_seen");
    endtask

    // Reference: word i lives at aligned base + 4i and should hold
    // seed + i; CHECK reads return memory unless marked bad.
    task automatic model_check(input logic [31:0] b, input int n,
                               input logic [31:0] sd,
                               output int fc, output logic [31:0] fa);
        logic [31:0] a;
        logic [31:0] d;
        fc = 0;
        fa = 0;
        for (int i = 0; i < n; i++) begin
            a = (b & ~32'h3) + 32'(4 * i);
            d = (bad_en && a == bad_addr) ? 32'hDEAD : mem[a[7:2]];
            if (d != sd + 32'(i)) begin
                if (fc == 0) fa = a;
                fc++;
            end
        end
    endtask

    task automatic chk_addrs(input logic [31:0] b, input int n,
                             input string tag);
        chk({tag, "_n"}, alog.size(), n);
        for (int i = 0; i < n; i++)
            if (i < alog.size())
                chk(tag, alog[i], (b & ~32'h3) + 32'(4 * i));
    endtask

    initial begin
        int fc;
        int d0;
        logic [31:0] fa;
        logic [31:0] b;
        logic [31:0] sd;
        int n;
        int idx;

        start = 0;
        mode = 0;
        base_addr = 0;
        word_cnt = 0;
        seed = 0;
        for (int i = 0; i < 64; i++) mem[i] = 0;

        #1;
        chk("rst_htrans", htrans, 0);
        chk("rst_haddr", haddr, 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_hwrite", hwrite, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        chk("rst_ffa", first_fail_addr, 0);
        chk("hsize", hsize, 3'b010);
        chk("hburst", hburst, 3'b000);
        chk("hprot", hprot, 4'b0011);
        step();
        step();
        rstn = 1;
        step();

        // FILL, no stalls.
        run(0, 32'h0001_0000, 4, 32'h100);
        chk_addrs(32'h0001_0000, 4, "fill_addr");
        for (int i = 0; i < 4; i++) begin
            if (i < acyc.size())
                chk("fill_acyc", acyc[i] - s_cyc, i + 1);
            if (i < wlog.size() && i < acyc.size()) begin
                chk("fill_wdata", wlog[i], 32'h100 + i);
                chk("fill_wcyc", wcyc[i] - acyc[i], 1);
            end
        end
        chk("fill_done_lat", done_cyc - s_cyc, 6);
        chk("fill_bus_err", bus_err, 0);

        // CHECK with a 2-cycle stall in word 1's data phase.
        stall_en = 1;
        stall_addr = 32'h0001_0004;
        stall_n = 2;
        run(1, 32'h0001_0000, 4, 32'h100);
        stall_en = 0;
        chk_addrs(32'h0001_0000, 4, "stall_addr");
        if (acyc.size() == 4)
            chk("stall_gap", acyc[2] - acyc[1], 3);
        chk("stall_stable", stab_viol, 0);
        chk("stall_done_lat", done_cyc - s_cyc, 8);
        chk("stall_fail_cnt", fail_cnt, 0);
        chk("stall_ffa", first_fail_addr, 0);

        // CHECK with one corrupted read.
        bad_en = 1;
        bad_addr = 32'h0001_0008;
        model_check(32'h0001_0000, 4, 32'h100, fc, fa);
        run(1, 32'h0001_0000, 4, 32'h100);
        bad_en = 0;
        chk_addrs(32'h0001_0000, 4, "bad_addr");
        chk("bad_fail_cnt", fail_cnt, fc);
        chk("bad_ffa", first_fail_addr, fa);
        chk("bad_fail_abs", fail_cnt, 1);
        chk("bad_ffa_abs", first_fail_addr, 32'h0001_0008);

        // Zero count.
        run(1, 32'h0001_0000, 0, 32'h100);
        chk("zero_naddr", alog.size(), 0);
        chk("zero_done_lat", done_cyc - s_cyc, 1);
        chk("zero_busy", busy_seen, 0);
        chk("zero_fail_cleared", fail_cnt, 0);

        // ERROR on word 3 of an 8-word FILL.
        err_en = 1;
        err_addr = 32'h0001_000C;
        run(0, 32'h0001_0000, 8, 32'h200);
        err_en = 0;
        chk("err_naddr", alog.size(), 4);
        chk("err_seen", err_cyc >= 0, 1);
        if (err_cyc >= 0 && err_cyc < 4095)
            chk("err_htrans_next", ht_at[err_cyc + 1], 0);
        chk("err_bus_err", bus_err, 1);
        chk("err_busy_after", busy, 0);

        // Async reset mid-FILL.
        clear_logs();
        mode = 0;
        base_addr = 32'h0001_0000;
        word_cnt = 8;
        seed = 32'h55;
        start = 1;
        step();
        start = 0;
        step();
        step();
        chk("rstmid_pre", htrans, 2'b10);
        rstn = 0;
        #1;
        chk("rstmid_htrans", htrans, 0);
        chk("rstmid_haddr", haddr, 0);
        chk("rstmid_hwdata", hwdata, 0);
        chk("rstmid_hwrite", hwrite, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_bus_err", bus_err, 0);
        step();
        rstn = 1;
        step();

        // Start while busy is ignored.
        clear_logs();
        d0 = done_n;
        mode = 0;
        base_addr = 32'h0001_0040;
        word_cnt = 5;
        seed = 32'h77;
        start = 1;
        step();
        start = 0;
        step();
        word_cnt = 2;
        base_addr = 32'h0001_0100;
        start = 1;
        step();
        start = 0;
        wait_done(d0, "busy_start_done");
        chk_addrs(32'h0001_0040, 5, "busy_start_addr");
        if (wlog.size() == 5)
            chk("busy_start_wd", wlog[4], 32'h7B);

        // Randomized fill/corrupt/check rounds.
        rnd_stall = 1;
        for (int r = 0; r < 4; r++) begin
            sd = $urandom;
            n = $urandom_range(1, 16);
            b = 32'h0001_0000 + ($urandom_range(0, 15) << 2);
            b = b | 32'($urandom_range(0, 3));
            run(0, b, 16'(n), sd);
            chk_addrs(b, n, "rnd_fill_addr");
            chk("rnd_fill_nw", wlog.size(), n);
            chk("rnd_stable", stab_viol, 0);
            model_check(b, n, sd, fc, fa);
            chk("rnd_model_clean", fc, 0);
            for (int k = 0; k < r; k++) begin
                idx = $urandom_range(0, n - 1);
                fa = (b & ~32'h3) + 32'(4 * idx);
                mem[fa[7:2]] = mem[fa[7:2]] ^ (32'h1 << k);
            end
            model_check(b, n, sd, fc, fa);
            run(1, b, 16'(n), sd);
            chk("rnd_fail_cnt", fail_cnt, fc);
            chk("rnd_ffa", first_fail_addr, fa);
            chk("rnd_bus_err", bus_err, 0);
        end
        rnd_stall = 0;

        // Address wrap past 2^32.
        run(0, 32'hFFFF_FFF9, 4, 32'h0);
        chk_addrs(32'hFFFF_FFF9, 4, "wrap_addr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
